mem_dump_reader: RTL and testbench



---
 rtl/mem_dump_pkg.sv | 14 +
 rtl/mem_dump_fifo.sv | 56 +++++
 rtl/mem_dump_reader.sv | 157 +++++++++++++++
 tb/tb_mem_dump_reader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and defaults for the RAM dump reader.
package mem_dump_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } dump_state_t;

   // Default output buffer depth; must be a power of two and at least 3.
   localparam int unsigned DUMP_FIFO_DEPTH = 4;

endpackage

// File: rtl/mem_dump_fifo.sv
// Show-ahead synchronous FIFO holding {addr, data} beats for the dump reader.
module mem_dump_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             pop_ok;

   // A pop on an empty buffer is dropped rather than corrupting the pointers.
   assign pop_ok  = pop_i && (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage array; contents are don't-care until the count says otherwise.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_i, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_dump_reader.sv
// Walks a RAM window through a synchronous read port and streams
// (address, byte) beats out over valid/ready.
//
// state    | meaning
// ST_IDLE  | waiting for start; read port released
// ST_READ  | issuing reads whenever the output buffer has credit
// ST_DRAIN | all reads issued; emptying buffer and inflight read
// ST_DONE  | one-cycle completion pulse, then back to idle
module mem_dump_reader
   import mem_dump_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = DUMP_FIFO_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   length_i,
   output logic                  bus_req_o,
   output logic                  mem_rd_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [ADDR_WIDTH-1:0] out_addr_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];
   localparam logic [ADDR_WIDTH:0] REM_LAST = {{ADDR_WIDTH{1'b0}}, 1'b1};

   dump_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic                  busy_q, bus_req_q, done_q;

   logic                  inflight_q;
   logic [ADDR_WIDTH-1:0] inflight_addr_q;

   logic [CW-1:0]         fifo_count;
   logic [EW-1:0]         fifo_head;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [CW:0]           credit_used;
   logic                  rd_en;
   logic                  drain_finish;

   // A read only issues when its returning byte is sure to find a free slot.
   assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
   assign rd_en       = (state_q == ST_READ) && (credit_used < DEPTH_W);

   assign fifo_push   = inflight_q;
   assign out_valid_o = (fifo_count != '0);
   assign fifo_pop    = out_valid_o && out_ready_i;

   // Finish once nothing is in flight and the last buffered beat is leaving.
   assign drain_finish = !inflight_q &&
                         ((fifo_count == '0) ||
                          ((fifo_count == CW'(1)) && fifo_pop));

   assign mem_rd_en_o = rd_en;
   assign mem_addr_o  = rd_en ? addr_q : '0;
   assign out_addr_o  = out_valid_o ? fifo_head[EW-1:DATA_WIDTH] : '0;
   assign out_data_o  = out_valid_o ? fifo_head[DATA_WIDTH-1:0] : '0;
   assign busy_o      = busy_q;
   assign bus_req_o   = bus_req_q;
   assign done_o      = done_q;

   mem_dump_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (reset_i),
      .push_i      (fifo_push),
      .push_data_i ({inflight_addr_q, mem_rd_data_i}),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .count_o     (fifo_count)
   );

   // Next-state, address walk and remaining-count decode.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               addr_d      = base_addr_i;
               remaining_d = length_i;
               state_d     = (length_i == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (rd_en) begin
               addr_d      = addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == REM_LAST) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_finish) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with registered status outputs decoded from the next state.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         bus_req_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         busy_q      <= (state_d == ST_READ) || (state_d == ST_DRAIN);
         bus_req_q   <= (state_d == ST_READ) || (state_d == ST_DRAIN);
         done_q      <= (state_d == ST_DONE);
      end
   end

   // Track the single outstanding read so its data lands with its address;
   // clearing it on reset discards a read that is still returning.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
      end else begin
         inflight_q <= rd_en;
         if (rd_en) begin
            inflight_addr_q <= addr_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized self-checking bench for mem_dump_reader against a RAM-image model.
module tb_mem_dump_reader;

   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          bus_req;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;

   logic [DW-1:0] ram [0:65535];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   // Synchronous-read RAM: data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= ram[mem_addr];
   end

   mem_dump_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .base_addr_i   (base_addr),
      .length_i      (length),
      .bus_req_o     (bus_req),
      .mem_rd_en_o   (mem_rd_en),
      .mem_addr_o    (mem_addr),
      .mem_rd_data_i (mem_rd_data),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_addr_o    (out_addr),
      .out_data_o    (out_data),
      .busy_o        (busy),
      .done_o        (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3*AW+2*DW+5-1:0] outs;
      reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
      repeat (3) tick();
      outs = {bus_req, mem_rd_en, mem_addr, out_valid, out_addr, out_data, busy, done, 16'h0000};
      n_total++;
      if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
      else n_pass++;
      reset = 1'b0;
      repeat (2) tick();
      n_total++;
      if ({busy, bus_req, mem_rd_en, out_valid, done} !== 5'b0)
         $display("FAIL idle_after_reset: got %b expected 00000", {busy, bus_req, mem_rd_en, out_valid, done});
      else n_pass++;
   endtask

   // Exact cycle-by-cycle schedule with the consumer always ready.
   task automatic test_stream(input string name, input logic [AW-1:0] b, input int n);
      logic [AW-1:0] ea;
      logic [AW-1:0] exp_maddr;
      logic [4:0]    exp_ctrl;
      logic [4:0]    act_ctrl;
      bit ev, ed, eb, er;
      out_ready = 1'b1; base_addr = b; length = (AW+1)'(n); start = 1'b1;
      for (int c = 1; c <= n + 5; c++) begin
         tick();
         start = 1'b0;
         ev = (n > 0) && (c >= 3) && (c <= n + 2);
         ed = (n == 0) ? (c == 1) : (c == n + 3);
         eb = (n > 0) && (c <= n + 2);
         er = (n > 0) && (c <= n);
         exp_ctrl = {ev, ed, eb, eb, er};
         act_ctrl = {out_valid, done, busy, bus_req, mem_rd_en};
         n_total++;
         if (act_ctrl !== exp_ctrl)
            $display("FAIL %s ctrl c%0d: got %b expected %b", name, c, act_ctrl, exp_ctrl);
         else n_pass++;
         exp_maddr = er ? AW'(b + c - 1) : '0;
         n_total++;
         if (mem_addr !== exp_maddr)
            $display("FAIL %s mem_addr c%0d: got %h expected %h", name, c, mem_addr, exp_maddr);
         else n_pass++;
         if (ev) begin
            ea = AW'(b + c - 3);
            n_total++;
            if ({out_addr, out_data} !== {ea, ram[ea]})
               $display("FAIL %s beat c%0d: got %h/%h expected %h/%h", name, c, out_addr, out_data, ea, ram[ea]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_basic();
      ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22;
      ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
      test_stream("basic", 16'h0200, 4);
   endtask

   task automatic test_wrap();
      test_stream("wrap", 16'hFFFE, 4);
   endtask

   task automatic test_zero_length();
      test_stream("zero_len", AW'($urandom), 0);
   endtask

   task automatic test_random_streams();
      for (int k = 0; k < 6; k++)
         test_stream("rand_stream", AW'($urandom), int'($urandom_range(1, 20)));
   endtask

   // Stalling consumer: order, stability while stalled, credit and completion.
   task automatic test_backpressure(input logic [AW-1:0] b, input int n, input bit random_ready);
      logic [3:0]    pat;
      logic [AW-1:0] ea;
      logic [AW-1:0] prev_addr;
      logic [DW-1:0] prev_data;
      bit            prev_stall;
      bit            finished;
      int            issued;
      int            accepted;
      pat = 4'b1001;
      issued = 0; accepted = 0; prev_stall = 0; finished = 0;
      prev_addr = '0; prev_data = '0;
      base_addr = b; length = (AW+1)'(n); start = 1'b1; out_ready = 1'b0;
      for (int c = 1; c <= 20 * n + 20 && !finished; c++) begin
         tick();
         start = 1'b0;
         out_ready = random_ready ? 1'($urandom) : pat[c % 4];
         if (mem_rd_en) begin
            ea = AW'(b + issued);
            issued++;
            n_total++;
            if (mem_addr !== ea) $display("FAIL bp_rd_addr: got %h expected %h", mem_addr, ea);
            else n_pass++;
            n_total++;
            if (issued - accepted > DEPTH)
               $display("FAIL bp_credit: got %0d outstanding expected <= %0d", issued - accepted, DEPTH);
            else n_pass++;
         end
         if (prev_stall) begin
            n_total++;
            if ({out_valid, out_addr, out_data} !== {1'b1, prev_addr, prev_data})
               $display("FAIL bp_stable: got %b/%h/%h expected 1/%h/%h", out_valid, out_addr, out_data, prev_addr, prev_data);
            else n_pass++;
         end
         if (out_valid) begin
            ea = AW'(b + accepted);
            n_total++;
            if ({out_addr, out_data} !== {ea, ram[ea]})
               $display("FAIL bp_beat: got %h/%h expected %h/%h", out_addr, out_data, ea, ram[ea]);
            else n_pass++;
            if (out_ready) accepted++;
         end
         prev_stall = out_valid && !out_ready;
         prev_addr  = out_addr;
         prev_data  = out_data;
         if (done) begin
            finished = 1;
            n_total++;
            if (accepted != n || issued != n)
               $display("FAIL bp_count: got %0d beats %0d reads expected %0d", accepted, issued, n);
            else n_pass++;
         end
      end
      if (!finished) begin
         n_total++;
         $display("FAIL bp_timeout: got no done expected done after %0d beats", n);
      end
      out_ready = 1'b1;
      tick();
   endtask

   // Reset after five beats of a long run, then a clean short run.
   task automatic test_reset_mid();
      int beats;
      logic [3*AW+2*DW+5-1:0] outs;
      beats = 0;
      base_addr = AW'($urandom); length = 17'd16; out_ready = 1'b1; start = 1'b1;
      for (int c = 0; c < 30 && beats < 5; c++) begin
         tick();
         start = 1'b0;
         if (out_valid && out_ready) beats++;
      end
      n_total++;
      if (beats != 5) $display("FAIL rst_mid_beats: got %0d expected 5", beats);
      else n_pass++;
      tick();
      reset = 1'b1;
      #1;
      outs = {bus_req, mem_rd_en, mem_addr, out_valid, out_addr, out_data, busy, done, 16'h0000};
      n_total++;
      if (outs !== '0) $display("FAIL rst_mid_outputs: got %h expected 0", outs);
      else n_pass++;
      tick();
      tick();
      reset = 1'b0;
      tick();
      test_stream("after_reset", 16'h0010, 2);
   endtask

   // Start pulses during READ and during DONE must be ignored.
   task automatic test_ignored_start();
      logic [AW-1:0] b;
      logic [AW-1:0] ea;
      int            n;
      int            accepted;
      bit            finished;
      b = AW'($urandom); n = 12; accepted = 0; finished = 0;
      base_addr = b; length = (AW+1)'(n); out_ready = 1'b1; start = 1'b1;
      for (int c = 1; c <= 60 && !finished; c++) begin
         tick();
         start = (c == 2);
         if (c == 2) begin
            base_addr = b + 16'h1234;
            length = 17'd3;
         end
         if (out_valid) begin
            ea = AW'(b + accepted);
            n_total++;
            if ({out_addr, out_data} !== {ea, ram[ea]})
               $display("FAIL ign_beat: got %h/%h expected %h/%h", out_addr, out_data, ea, ram[ea]);
            else n_pass++;
            accepted++;
         end
         if (done) begin
            finished = 1;
            n_total++;
            if (accepted != n) $display("FAIL ign_count: got %0d expected %0d", accepted, n);
            else n_pass++;
         end
      end
      if (!finished) begin
         n_total++;
         $display("FAIL ign_timeout: got no done expected done");
      end
      start = 1'b1; base_addr = 16'h4000; length = 17'd5;
      tick();
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_total++;
         if ({busy, bus_req, mem_rd_en, done} !== 4'b0)
            $display("FAIL ign_done_start: got %b expected 0000", {busy, bus_req, mem_rd_en, done});
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = DW'($urandom);
      test_reset();
      test_basic();
      test_wrap();
      test_zero_length();
      test_random_streams();
      test_backpressure(16'h0200, 4, 1'b0);
      test_backpressure(AW'($urandom), 13, 1'b0);
      for (int k = 0; k < 3; k++)
         test_backpressure(AW'($urandom), int'($urandom_range(1, 24)), 1'b1);
      test_backpressure(16'hFFFD, 6, 1'b1);
      test_reset_mid();
      test_ignored_start();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
